d8_uart_loader: RTL and testbench

- Serial boot loader for the d8 core.
- Receives a framed program image on a UART line and writes it word by word into the instruction memory write port.
- Holds the core in reset until a complete, checksum-valid image has been written.
- Sits beside d8_top. It drives the instruction memory write port and the core reset, replacing the simulation-only preload of instruction memory.

---
 rtl/d8_uart_loader_pkg.sv | 25 ++
 rtl/d8_uart_loader_if.sv | 13 +
 rtl/d8_uart_rx.sv | 91 +++++++++
 rtl/d8_uart_loader.sv | 149 ++++++++++++++
 tb/tb_d8_uart_loader.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/d8_uart_loader_pkg.sv
// Shared types and constants for the d8 serial boot loader and its UART receiver.
package d8_uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_RUN
    } ld_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_e;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    function automatic int bytes_per_word(input int insn_w);
        return insn_w / 8;
    endfunction

endpackage

// File: rtl/d8_uart_loader_if.sv
// Instruction memory write port driven by the boot loader.
interface d8_uart_loader_if #(
    parameter int ADDR_W = 8,
    parameter int INSN_W = 16
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [INSN_W-1:0] mem_dat;

    // mem_we is a single-cycle strobe; adr/dat are valid only while it is high.
    modport master (output mem_we, output mem_adr, output mem_dat);
    modport slave  (input  mem_we, input  mem_adr, input  mem_dat);
endinterface

// File: rtl/d8_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, glitch-rejecting start bit.
module d8_uart_rx
    import d8_uart_loader_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       rx_stb_o,
    output logic [7:0] rx_dat_o,
    output logic       rx_ferr_o
);
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);

    // [0] first flop, [1] synchronised line, [2] previous synchronised value
    logic [2:0]       sync_q;
    rx_state_e        st_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic             stb_q;
    logic [7:0]       dat_q;
    logic             ferr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 3'b111;
            st_q   <= R_IDLE;
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            stb_q  <= 1'b0;
            dat_q  <= '0;
            ferr_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], rx_i};
            stb_q  <= 1'b0;
            ferr_q <= 1'b0;
            case (st_q)
                R_IDLE: begin
                    if (!sync_q[1] && sync_q[2]) begin
                        st_q  <= R_START;
                        cnt_q <= '0;
                    end
                end
                R_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        st_q  <= sync_q[1] ? R_IDLE : R_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        sh_q  <= {sync_q[1], sh_q[7:1]};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) st_q <= R_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                R_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        st_q  <= R_IDLE;
                        if (sync_q[1]) begin
                            stb_q <= 1'b1;
                            dat_q <= sh_q;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: st_q <= R_IDLE;
            endcase
        end
    end

    assign rx_stb_o  = stb_q;
    assign rx_dat_o  = dat_q;
    assign rx_ferr_o = ferr_q;

endmodule

// File: rtl/d8_uart_loader.sv
// Serial boot loader: parses SYNC/LEN/data/CHK frames, writes instruction memory, gates core reset.
module d8_uart_loader
    import d8_uart_loader_pkg::*;
#(
    parameter int         CLK_DIV = 868,
    parameter int         ADDR_W  = 8,
    parameter int         INSN_W  = 16,
    parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    rx,
    d8_uart_loader_if.master        mem,
    output logic                    core_rst,
    output logic                    done,
    output logic                    err,
    output ld_state_e               dbg_state
);
    localparam int BPW    = bytes_per_word(INSN_W);
    localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CNT_W  = ((ADDR_W > 8) ? ADDR_W : 8) + 1;

    logic       rx_stb;
    logic [7:0] rx_dat;
    logic       rx_ferr;

    d8_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .rx_i     (rx),
        .rx_stb_o (rx_stb),
        .rx_dat_o (rx_dat),
        .rx_ferr_o(rx_ferr)
    );

    ld_state_e         state_q;
    logic [CNT_W-1:0]  words_q;
    logic [CNT_W-1:0]  wcnt_q;
    logic [ADDR_W-1:0] adr_q;
    logic [BIDX_W-1:0] bidx_q;
    logic [INSN_W-1:0] word_q;
    logic [7:0]        sum_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_adr_q;
    logic [INSN_W-1:0] mem_dat_q;
    logic              core_rst_q;
    logic              done_q;
    logic              err_q;

    logic [INSN_W-1:0] word_d;
    logic [7:0]        sum_d;
    logic [CNT_W-1:0]  wcnt_d;
    logic [CNT_W-1:0]  len_words;
    logic              last_byte;

    // Words arrive big-endian, so each byte shifts in from the bottom.
    assign word_d    = (word_q << 8) | INSN_W'(rx_dat);
    assign sum_d     = sum_q + rx_dat;
    assign wcnt_d    = wcnt_q + CNT_W'(1);
    assign len_words = (rx_dat == 8'd0) ? (CNT_W'(1) << ADDR_W) : CNT_W'(rx_dat);
    assign last_byte = (bidx_q == BIDX_W'(BPW - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            words_q    <= '0;
            wcnt_q     <= '0;
            adr_q      <= '0;
            bidx_q     <= '0;
            word_q     <= '0;
            sum_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_adr_q  <= '0;
            mem_dat_q  <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (rx_ferr && (state_q inside {ST_LEN, ST_DATA, ST_CHK})) begin
                err_q      <= 1'b1;
                done_q     <= 1'b0;
                core_rst_q <= 1'b1;
                state_q    <= ST_IDLE;
            end else if (rx_stb) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_dat == SYNC) state_q <= ST_LEN;
                    end
                    ST_LEN: begin
                        words_q <= len_words;
                        wcnt_q  <= '0;
                        adr_q   <= '0;
                        sum_q   <= '0;
                        bidx_q  <= '0;
                        word_q  <= '0;
                        state_q <= ST_DATA;
                    end
                    ST_DATA: begin
                        word_q <= word_d;
                        sum_q  <= sum_d;
                        if (last_byte) begin
                            bidx_q    <= '0;
                            mem_we_q  <= 1'b1;
                            mem_adr_q <= adr_q;
                            mem_dat_q <= word_d;
                            adr_q     <= adr_q + ADDR_W'(1);
                            wcnt_q    <= wcnt_d;
                            if (wcnt_d == words_q) state_q <= ST_CHK;
                        end else begin
                            bidx_q <= bidx_q + BIDX_W'(1);
                        end
                    end
                    ST_CHK: begin
                        if (rx_dat == sum_q) begin
                            done_q     <= 1'b1;
                            err_q      <= 1'b0;
                            core_rst_q <= 1'b0;
                            state_q    <= ST_RUN;
                        end else begin
                            done_q     <= 1'b0;
                            err_q      <= 1'b1;
                            core_rst_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (rx_dat == SYNC) begin
                            core_rst_q <= 1'b1;
                            done_q     <= 1'b0;
                            err_q      <= 1'b0;
                            state_q    <= ST_LEN;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign mem.mem_we  = mem_we_q;
    assign mem.mem_adr = mem_adr_q;
    assign mem.mem_dat = mem_dat_q;
    assign core_rst    = core_rst_q;
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_d8_uart_loader.sv
// Bench for d8_uart_loader: serial frame driver, write scoreboard, status checks.
module tb_d8_uart_loader;
    import d8_uart_loader_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int ADDR_W  = 8;
    localparam int INSN_W  = 16;

    logic      sys_clk = 1'b0;
    logic      sys_rst = 1'b1;
    logic      rx      = 1'b1;
    logic      core_rst;
    logic      done;
    logic      err;
    ld_state_e dbg_state;

    d8_uart_loader_if #(.ADDR_W(ADDR_W), .INSN_W(INSN_W)) mem_if ();

    d8_uart_loader #(
        .CLK_DIV(CLK_DIV),
        .ADDR_W (ADDR_W),
        .INSN_W (INSN_W),
        .SYNC   (8'hA5)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .rx       (rx),
        .mem      (mem_if),
        .core_rst (core_rst),
        .done     (done),
        .err      (err),
        .dbg_state(dbg_state)
    );

    always #5 sys_clk = ~sys_clk;

    int n_pass  = 0;
    int n_total = 0;
    int wr_cnt  = 0;
    int stb_cnt = 0;

    logic [23:0] exp_q[$];
    logic [15:0] img[$];
    logic [23:0] mon_e;
    logic        prev_we = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Write scoreboard: every mem_we must match the next queued (adr, dat).
    always @(negedge sys_clk) begin
        if (mem_if.mem_we === 1'b1) begin
            wr_cnt++;
            chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("we_unexpected", {31'd0, mem_if.mem_we}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_adr", {24'd0, mem_if.mem_adr}, {24'd0, mon_e[23:16]});
                chk("wr_dat", {16'd0, mem_if.mem_dat}, {16'd0, mon_e[15:0]});
            end
        end
        prev_we = mem_if.mem_we;
    end

    always @(posedge sys_clk) if (dut.u_rx.rx_stb_o) stb_cnt++;

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CLK_DIV) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        drive_bit(1'b1);
    endtask

    task automatic send_image(input logic [7:0] len_b, input bit bad_chk);
        logic [7:0] sum;
        sum = 8'd0;
        for (int i = 0; i < img.size(); i++) exp_q.push_back({8'(i), img[i]});
        send_byte(8'hA5, 1'b1);
        send_byte(len_b, 1'b1);
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i][15:8], 1'b1);
            send_byte(img[i][7:0], 1'b1);
            sum = sum + img[i][15:8] + img[i][7:0];
        end
        send_byte(bad_chk ? sum + 8'd1 : sum, 1'b1);
    endtask

    task automatic check_status(input string tag, input logic e_done, input logic e_err,
                                input logic e_rst, input ld_state_e e_st);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
        chk({tag, "_core_rst"}, {31'd0, core_rst}, {31'd0, e_rst});
        chk({tag, "_state"}, 32'(dbg_state), 32'(e_st));
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_we"}, {31'd0, mem_if.mem_we}, 32'd0);
        chk({tag, "_adr"}, {24'd0, mem_if.mem_adr}, 32'd0);
        chk({tag, "_dat"}, {16'd0, mem_if.mem_dat}, 32'd0);
        check_status(tag, 1'b0, 1'b0, 1'b1, ST_IDLE);
    endtask

    task automatic load_small_image();
        img.delete();
        img.push_back(16'h1234);
        img.push_back(16'hABCD);
    endtask

    initial begin
        int w0;
        int s0;

        // Reset, then 100 idle bit times
        repeat (5) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_reset_values("reset");
        repeat (100 * CLK_DIV) @(negedge sys_clk);
        check_reset_values("idle");
        chk("idle_writes", wr_cnt, 32'd0);

        // Junk bytes before SYNC are ignored, then a valid two-word image
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        load_small_image();
        send_image(8'h02, 1'b0);
        check_status("valid", 1'b1, 1'b0, 1'b0, ST_RUN);
        chk("valid_writes", wr_cnt, 32'd2);

        // Reload from RUN with a bad checksum: writes land, core held
        w0 = wr_cnt;
        load_small_image();
        send_image(8'h02, 1'b1);
        check_status("badchk", 1'b0, 1'b1, 1'b1, ST_IDLE);
        chk("badchk_writes", wr_cnt - w0, 32'd2);

        // Next valid frame clears err and releases the core
        img.delete();
        img.push_back(16'h00FF);
        img.push_back(16'h8001);
        img.push_back(16'h7E42);
        send_image(8'h03, 1'b0);
        check_status("recover", 1'b1, 1'b0, 1'b0, ST_RUN);

        // Stop bit low on the third data byte
        w0 = wr_cnt;
        exp_q.push_back({8'd0, 16'h1234});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b0);
        check_status("ferr", 1'b0, 1'b1, 1'b1, ST_IDLE);
        chk("ferr_writes", wr_cnt - w0, 32'd1);

        // One-cycle low glitch on an idle line
        s0 = stb_cnt;
        rx = 1'b0;
        @(negedge sys_clk);
        rx = 1'b1;
        repeat (5 * CLK_DIV) @(negedge sys_clk);
        chk("glitch_stb", stb_cnt - s0, 32'd0);
        chk("glitch_state", 32'(dbg_state), 32'(ST_IDLE));

        // LEN=0: full 256-word image, address wraps back to 0 without a 257th write
        w0 = wr_cnt;
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back(16'(i * 3 + 16'h2000));
        send_image(8'h00, 1'b0);
        check_status("len0", 1'b1, 1'b0, 1'b0, ST_RUN);
        chk("len0_writes", wr_cnt - w0, 32'd256);

        // sys_rst mid-DATA on a reload frame discards the partial word
        w0 = wr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        chk("midrst_state", 32'(dbg_state), 32'(ST_DATA));
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_reset_values("midrst");
        chk("midrst_writes", wr_cnt - w0, 32'd0);

        // Fresh frame after reset loads cleanly
        load_small_image();
        send_image(8'h02, 1'b0);
        check_status("after_rst", 1'b1, 1'b0, 1'b0, ST_RUN);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
